// File: rtl/modexp_stream.sv
// Right-to-left square-and-multiply modexp engine sharing one Montgomery-based modular multiplier.
// Optional MODEXP_EARLY_EXIT_EN stops once no set exponent bits remain; otherwise latency is fixed at 2*EXP_WIDTH.

module multiplicator #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] modulant,
  input  logic [W-1:0] r_div_two,
  input  logic [W-1:0] r_squared,
  output logic [W-1:0] p
);

  // Bit-serial Montgomery reduction: one halving per bit of R = 2*r_div_two.
  function automatic logic [W-1:0] redc(input logic [2*W:0] t_in,
                                        input logic [W-1:0] m,
                                        input logic [W-1:0] rdt);
    logic [2*W:0] t;
    logic [2*W:0] m_ext;
    t     = t_in;
    m_ext = {{(W+1){1'b0}}, m};
    for (int i = 0; i < W; i++) begin
      if ((rdt >> i) != '0) begin
        if (t[0]) t = t + m_ext;
        t = t >> 1;
      end
    end
    if (t >= m_ext) t = t - m_ext;
    return t[W-1:0];
  endfunction

  logic [2*W:0] ab_full;
  logic [2*W:0] ur_full;
  logic [W-1:0] ab_mont;

  // a*b*R^-1, then multiply by R^2 and reduce again to strip the R^-1.
  always_comb begin
    ab_full = {{(W+1){1'b0}}, a} * {{(W+1){1'b0}}, b};
    ab_mont = redc(ab_full, modulant, r_div_two);
    ur_full = {{(W+1){1'b0}}, ab_mont} * {{(W+1){1'b0}}, r_squared};
    p       = redc(ur_full, modulant, r_div_two);
  end

endmodule

module modexp_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] R_div_two,
  input  logic [DATA_WIDTH-1:0] R_squared,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy
);

  localparam int CW = $clog2(EXP_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQR, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sq_q, sq_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mod_q, mod_d;
  logic [DATA_WIDTH-1:0] rdt_q, rdt_d;
  logic [DATA_WIDTH-1:0] rsq_q, rsq_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_p;
  logic                  last;

  assign mul_a = (state_q == S_SQR) ? sq_q : res_q;

  multiplicator #(.W(DATA_WIDTH)) u_mul (
    .a         (mul_a),
    .b         (sq_q),
    .modulant  (mod_q),
    .r_div_two (rdt_q),
    .r_squared (rsq_q),
    .p         (mul_p)
  );

`ifdef MODEXP_EARLY_EXIT_EN
  assign last = (cnt_q == CNT_LAST) || ((exp_q >> 1) == '0);
`else
  assign last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d     = state_q;
    sq_d        = sq_q;
    res_d       = res_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    mod_d       = mod_q;
    rdt_d       = rdt_q;
    rsq_d       = rsq_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    out_d       = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sq_d       = base;
          res_d      = DATA_WIDTH'(1);
          exp_d      = exponent;
          cnt_d      = '0;
          mod_d      = modulant;
          rdt_d      = R_div_two;
          rsq_d      = R_squared;
          state_d    = S_MUL;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_MUL: begin
        // The product is always evaluated so zero bits cost the same time.
        if (exp_q[0]) res_d = mul_p;
        state_d = S_SQR;
      end
      S_SQR: begin
        sq_d  = mul_p;
        exp_d = exp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          out_d       = res_q;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sq_q        <= '0;
      res_q       <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      mod_q       <= '0;
      rdt_q       <= '0;
      rsq_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      sq_q        <= sq_d;
      res_q       <= res_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      rdt_q       <= rdt_d;
      rsq_q       <= rsq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_modexp_stream.sv
// Randomised bench for modexp_stream checked every cycle against a behavioural phase/countdown model.
module tb_modexp_stream;

  localparam int DW = 8;
  localparam int EW = 8;

`ifdef MODEXP_EARLY_EXIT_EN
  localparam int L_3_5 = 6;
  localparam int L_EXP0 = 2;
`else
  localparam int L_3_5 = 16;
  localparam int L_EXP0 = 16;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] base;
  logic [EW-1:0] exponent;
  logic [DW-1:0] modulant;
  logic [DW-1:0] R_div_two;
  logic [DW-1:0] R_squared;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_dat;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  modexp_stream #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .exponent  (exponent),
    .modulant  (modulant),
    .R_div_two (R_div_two),
    .R_squared (R_squared),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_dat),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int ref_modexp(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int lat(input int e);
`ifdef MODEXP_EARLY_EXIT_EN
    int p;
    p = -1;
    for (int i = 0; i < EW; i++) if (((e >> i) & 1) != 0) p = i;
    return (p + 1 < 1) ? 2 : 2 * (p + 1);
`else
    return 2 * EW + 0 * e;
`endif
  endfunction

  function automatic int rsq_of(input int m);
    int r;
    r = (1 << DW) % m;
    return (r * r) % m;
  endfunction

  // Behavioural model: phase 0 idle, 1 computing (countdown), 2 result held.
  int m_phase = 0;
  int m_left  = 0;
  int m_res   = 0;
  bit started = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      started = 1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_phase = 1;
             m_left  = lat(int'(exponent));
             m_res   = ref_modexp(int'(base), int'(exponent), int'(modulant));
           end
        1: begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("in_ready", {31'b0, in_ready}, (m_phase == 0) ? 32'd1 : 32'd0);
      chk("busy", {31'b0, busy}, (m_phase == 1) ? 32'd1 : 32'd0);
      chk("out_valid", {31'b0, out_valid}, (m_phase == 2) ? 32'd1 : 32'd0);
      if (m_phase == 2) chk("out", {24'b0, out_dat}, m_res);
    end
  end

  // Entered at a negedge or just after a posedge; returns just after a negedge.
  task automatic run_op(input int b, input int e, input int m, input int rsq,
                        input int exp_out, input int exp_lat, input int hold, input bit noise);
    int n;
    bit got;
    base      = DW'(b);
    exponent  = EW'(e);
    modulant  = DW'(m);
    R_squared = DW'(rsq);
    R_div_two = 8'd128;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    base      = DW'($urandom);
    exponent  = EW'($urandom);
    modulant  = DW'($urandom);
    R_squared = DW'($urandom);
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (out_valid === 1'b1) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required %0d", n, exp_lat);
    end else begin
      chk("latency", n, exp_lat);
      chk("result", {24'b0, out_dat}, exp_out);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      if (noise) begin
        in_valid = 1'($urandom);
        base     = DW'($urandom);
      end
      @(negedge clock);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      chk("hold_out", {24'b0, out_dat}, exp_out);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("post_ack_out_valid", {31'b0, out_valid}, 0);
    chk("post_ack_in_ready", {31'b0, in_ready}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, b, e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base      = '0;
    exponent  = '0;
    modulant  = '0;
    R_div_two = 8'd128;
    R_squared = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_out", {24'b0, out_dat}, 0);

    chk("model_3^5%7", ref_modexp(3, 5, 7), 5);
    chk("model_2^255%13", ref_modexp(2, 255, 13), 8);
    chk("model_5^0%7", ref_modexp(5, 0, 7), 1);
    chk("model_rsq13", rsq_of(13), 3);
    chk("model_lat5", lat(5), L_3_5);

    run_op(3, 5, 7, 2, 5, L_3_5, 0, 0);
    run_op(2, 255, 13, 3, 8, 16, 1, 0);
    run_op(5, 0, 7, 2, 1, L_EXP0, 0, 0);
    run_op(3, 5, 7, 2, 5, L_3_5, 5, 1);

    // Reset lands on the fourth edge after accept.
    base = 8'd3; exponent = 8'd5; modulant = 8'd7; R_squared = 8'd2;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_out", {24'b0, out_dat}, 0);
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    repeat (20) @(negedge clock);
    run_op(3, 5, 7, 2, 5, L_3_5, 0, 0);

    for (int k = 0; k < 40; k++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      b = $urandom_range(0, m - 1);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      run_op(b, e, m, rsq_of(m), ref_modexp(b, e, m), lat(e), $urandom_range(0, 3), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/modexp_stream.md
# modexp_stream

Parametrised, handshaked modular exponentiation engine computing base^exponent mod modulant with the right-to-left square-and-multiply method. It time-shares a single combinational `multiplicator` instance between the multiply and square steps. Operands are captured on a valid/ready handshake and the result is held until the consumer accepts it. It sits between the operand sequencer and the result sink of the modular-arithmetic datapath.

## Interface
- DATA_WIDTH, 8: width of base, modulant, Montgomery constants and result.
- EXP_WIDTH, 8: width of the exponent; independent of DATA_WIDTH.
- clock  in  1  rising-edge clock; one clock; all state on this edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- base  in  DATA_WIDTH  base, must be < modulant.
- exponent  in  EXP_WIDTH  exponent.
- modulant  in  DATA_WIDTH  odd modulus, > 1.
- R_div_two  in  DATA_WIDTH  Montgomery constant R/2, with R = 2^DATA_WIDTH.
- R_squared  in  DATA_WIDTH  R^2 mod modulant.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  DATA_WIDTH  result; meaningful only while out_valid.
- busy  out  1  high in MUL or SQR.

## Operation
- Accept occurs when in_valid && in_ready at a clock edge. At accept the engine registers base into sq, 1 into res, exponent into exp, modulant, R_div_two and R_squared into local registers, and 0 into cnt. State goes to MUL. Inputs may change after accept.
- A single multiplicator computes a*b mod modulant from the registered constants. The a/b mux selects (res, sq) in MUL and (sq, sq) in SQR.
- States and transitions:
  - IDLE → MUL on accept.
  - MUL: if exp[0], res ← res·sq mod m; otherwise res holds. The multiply is still evaluated. Next state is SQR.
  - SQR: sq ← sq·sq mod m, exp ← exp >> 1, cnt ← cnt + 1. Next state is DONE on the termination condition, otherwise MUL.
  - DONE: out_valid = 1, out = res. Go to IDLE when out_ready is high.
- Termination without the macro: cnt == EXP_WIDTH−1 before the increment, so all EXP_WIDTH bits are processed.
- Exponent 0 gives out = 1.
- cnt is $clog2(EXP_WIDTH)+1 bits wide and never wraps.
- in_valid outside IDLE is ignored; nothing is queued.
- Results for base ≥ modulant, even modulant, or modulant ≤ 1 are unspecified.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, out 0. res, sq, exp and cnt are all 0.
- Latency: with accept at edge k, out_valid rises after edge k+L.
  - Without the macro, L = 2·EXP_WIDTH, independent of data.
  - With the macro, L = 2·max(1, p+1), where p is the index of the exponent's MSB set bit.
- out and out_valid stay stable while out_ready is low.
- The DONE→IDLE transition happens on the edge where out_ready is sampled high. in_ready rises in the next cycle. There is no same-cycle accept while in DONE, so peak throughput is one result per L+2 cycles.
- Reset asserted in any state: the next edge returns all state to reset values and the in-flight operation is discarded with no out_valid. Reset has priority over accept and out_ready.

## Configuration
- MODEXP_EARLY_EXIT_EN defined: SQR also terminates when (exp >> 1) == 0. Latency depends on the exponent.
- MODEXP_EARLY_EXIT_EN undefined: latency is constant at 2·EXP_WIDTH (timing-side-channel-safe mode). Dummy multiplies run for zero exponent bits.
- out is identical in both modes.

## Test plan
DATA_WIDTH=8, EXP_WIDTH=8.
- base=3, exp=5, m=7, R_div_two=128, R_squared=2 → out=5. Without the macro, out_valid occurs exactly 16 cycles after accept. With the macro, 6 cycles.
- base=2, exp=255, m=13, R_squared=3 → out=8, latency 16 in both modes.
- exp=0, base=5, m=7 → out=1. Latency is 16 without the macro and 2 with it.
- Hold out_ready low for 5 cycles in DONE → out_valid and out stay stable and in_ready=0. in_valid pulses during this window are ignored. out_ready=1 → out_valid falls next edge, then in_ready=1.
- Assert reset for 1 cycle at cycle 4 of an operation → no out_valid. The next cycle shows in_ready=1, busy=0, out=0. A new operation, 3^5 mod 7, then returns 5.
- Change base, modulant and R_squared one cycle after accept → the result uses the captured values.
